// File: rtl/tug_round_controller_pkg.sv
// Shared types and constants for the tug-of-war round controller.
package tug_round_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/tug_round_controller_if.sv
// Press inputs and rope/score outputs of the round controller.
interface tug_round_controller_if #(
  parameter int NUM_LIGHTS = 9,
  parameter int SCORE_MAX  = 7
);
  localparam int PW = $clog2(NUM_LIGHTS);
  localparam int SW = $clog2(SCORE_MAX + 1);

  logic          p1_level;
  logic          p2_level;
  logic          start;
  logic          round_active;
  logic [PW-1:0] position;
  logic          move_left;
  logic          move_right;
  logic [1:0]    winner;
  logic [SW-1:0] p1_score;
  logic [SW-1:0] p2_score;

  modport master (
    output p1_level, p2_level, start,
    input  round_active, position, move_left, move_right, winner, p1_score, p2_score
  );

  modport slave (
    input  p1_level, p2_level, start,
    output round_active, position, move_left, move_right, winner, p1_score, p2_score
  );
endinterface

// File: rtl/tug_round_controller_press_gate.sv
// Rising-edge press detector with a post-press lockout window.
// press is combinational so the caller can register its effect on the same edge.
module press_gate #(
  parameter int LOCKOUT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic press
);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  logic          prev;
  logic [LW-1:0] lock;

  assign press = level && !prev && (lock == '0);

  // prev resets high so a key held through reset is not seen as a press
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b1;
      lock <= '0;
    end else begin
      prev <= level;
      if (press)
        lock <= LW'(LOCKOUT_CYCLES);
      else if (lock != '0)
        lock <= lock - LW'(1);
    end
  end
endmodule

// File: rtl/tug_round_controller.sv
// Referee for one tug-of-war round: arbitrates presses onto the rope position,
// sequences IDLE/PLAY/DONE and keeps saturating per-player scores.
module tug_round_controller
  import tug_round_controller_pkg::*;
#(
  parameter int NUM_LIGHTS     = 9,
  parameter int LOCKOUT_CYCLES = 4,
  parameter int SCORE_MAX      = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  tug_round_controller_if.slave  bus
);
  localparam int PW = $clog2(NUM_LIGHTS);
  localparam int SW = $clog2(SCORE_MAX + 1);
  localparam logic [PW-1:0] CENTRE    = PW'((NUM_LIGHTS - 1) / 2);
  localparam logic [PW-1:0] NEAR_P2   = PW'(NUM_LIGHTS - 2);
  localparam logic [SW-1:0] SCORE_TOP = SW'(SCORE_MAX);

  logic p1_press;
  logic p2_press;

  press_gate #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_gate_p1 (
    .clk   (clk),
    .reset (reset),
    .level (bus.p1_level),
    .press (p1_press)
  );

  press_gate #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_gate_p2 (
    .clk   (clk),
    .reset (reset),
    .level (bus.p2_level),
    .press (p2_press)
  );

  state_t        state;
  logic [PW-1:0] pos;
  logic          mv_left;
  logic          mv_right;
  logic [1:0]    win;
  logic [SW-1:0] score1;
  logic [SW-1:0] score2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pos      <= CENTRE;
      mv_left  <= 1'b0;
      mv_right <= 1'b0;
      win      <= WIN_NONE;
      score1   <= '0;
      score2   <= '0;
    end else begin
      mv_left  <= 1'b0;
      mv_right <= 1'b0;
      case (state)
        IDLE: begin
          pos <= CENTRE;
          if (bus.start)
            state <= PLAY;
        end
        PLAY: begin
          // start takes priority; simultaneous presses cancel each other
          if (bus.start) begin
            pos <= CENTRE;
          end else if (p1_press && !p2_press) begin
            pos     <= pos - PW'(1);
            mv_left <= 1'b1;
            if (pos == PW'(1)) begin
              win   <= WIN_P1;
              state <= DONE;
              if (score1 != SCORE_TOP)
                score1 <= score1 + SW'(1);
            end
          end else if (p2_press && !p1_press) begin
            pos      <= pos + PW'(1);
            mv_right <= 1'b1;
            if (pos == NEAR_P2) begin
              win   <= WIN_P2;
              state <= DONE;
              if (score2 != SCORE_TOP)
                score2 <= score2 + SW'(1);
            end
          end
        end
        DONE: begin
          if (bus.start) begin
            pos   <= CENTRE;
            win   <= WIN_NONE;
            state <= PLAY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.round_active = (state == PLAY);
  assign bus.position     = pos;
  assign bus.move_left    = mv_left;
  assign bus.move_right   = mv_right;
  assign bus.winner       = win;
  assign bus.p1_score     = score1;
  assign bus.p2_score     = score2;
endmodule

// File: tb/tb_tug_round_controller.sv
// Directed bench with a cycle-level game model checked on every falling edge.
module tb_tug_round_controller;
  localparam int N      = 9;
  localparam int LOCK   = 4;
  localparam int SMAX   = 7;
  localparam int CENTRE = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tug_round_controller_if #(.NUM_LIGHTS(N), .SCORE_MAX(SMAX)) bus ();

  tug_round_controller #(
    .NUM_LIGHTS     (N),
    .LOCKOUT_CYCLES (LOCK),
    .SCORE_MAX      (SMAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: game phase 0 waiting, 1 playing, 2 finished; lockout as a "next allowed cycle"
  int cyc = 0;
  int m_phase = 0, m_pos = CENTRE, m_ml = 0, m_mr = 0, m_win = 0, m_s1 = 0, m_s2 = 0;
  int prev1 = 1, prev2 = 1, ok1 = 0, ok2 = 0;

  always @(posedge clk) begin
    bit a1, a2;
    cyc++;
    if (reset) begin
      m_phase = 0; m_pos = CENTRE; m_ml = 0; m_mr = 0; m_win = 0; m_s1 = 0; m_s2 = 0;
      prev1 = 1; prev2 = 1; ok1 = cyc; ok2 = cyc;
    end else begin
      a1 = bus.p1_level && (prev1 == 0) && (cyc >= ok1);
      a2 = bus.p2_level && (prev2 == 0) && (cyc >= ok2);
      if (a1) ok1 = cyc + LOCK + 1;
      if (a2) ok2 = cyc + LOCK + 1;
      prev1 = bus.p1_level;
      prev2 = bus.p2_level;
      m_ml = 0; m_mr = 0;
      if (m_phase == 0) begin
        m_pos = CENTRE;
        if (bus.start) m_phase = 1;
      end else if (m_phase == 1) begin
        if (bus.start) m_pos = CENTRE;
        else if (a1 && !a2) begin
          m_pos--; m_ml = 1;
          if (m_pos == 0) begin m_win = 1; m_phase = 2; m_s1 = (m_s1 < SMAX) ? m_s1 + 1 : SMAX; end
        end else if (a2 && !a1) begin
          m_pos++; m_mr = 1;
          if (m_pos == N - 1) begin m_win = 2; m_phase = 2; m_s2 = (m_s2 < SMAX) ? m_s2 + 1 : SMAX; end
        end
      end else if (bus.start) begin
        m_pos = CENTRE; m_win = 0; m_phase = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_position", bus.position, m_pos);
      chk("cyc_move_left", bus.move_left, m_ml);
      chk("cyc_move_right", bus.move_right, m_mr);
      chk("cyc_winner", bus.winner, m_win);
      chk("cyc_p1_score", bus.p1_score, m_s1);
      chk("cyc_p2_score", bus.p2_score, m_s2);
      chk("cyc_round_active", bus.round_active, m_phase == 1);
      chk("cyc_no_double_move", bus.move_left && bus.move_right, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    chk("start_position", bus.position, CENTRE);
    chk("start_winner", bus.winner, 0);
    chk("start_active", bus.round_active, 1);
  endtask

  task automatic p1_press(input int exp_pos, input int exp_mv);
    bus.p1_level = 1'b1;
    tick(1);
    chk("p1_position", bus.position, exp_pos);
    chk("p1_move_left", bus.move_left, exp_mv);
    bus.p1_level = 1'b0;
    tick(5);
  endtask

  task automatic p2_press(input int exp_pos, input int exp_mv);
    bus.p2_level = 1'b1;
    tick(1);
    chk("p2_position", bus.position, exp_pos);
    chk("p2_move_right", bus.move_right, exp_mv);
    bus.p2_level = 1'b0;
    tick(5);
  endtask

  initial begin
    bus.p1_level = 1'b1;
    bus.p2_level = 1'b0;
    bus.start    = 1'b0;
    reset        = 1'b1;
    tick(1);
    cmp_en = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("rst_position", bus.position, CENTRE);
    chk("rst_winner", bus.winner, 0);
    chk("rst_p1_score", bus.p1_score, 0);
    chk("rst_p2_score", bus.p2_score, 0);
    chk("rst_active", bus.round_active, 0);

    // 1: key held through reset is not a press
    do_start();
    tick(2);
    chk("held_no_move", bus.move_left, 0);
    chk("held_position", bus.position, CENTRE);
    bus.p1_level = 1'b0;
    tick(1);
    p1_press(3, 1);

    // 2: P1 pulls the rope to its end
    do_start();
    p1_press(3, 1);
    p1_press(2, 1);
    p1_press(1, 1);
    p1_press(0, 1);
    chk("p1_win_winner", bus.winner, 1);
    chk("p1_win_score", bus.p1_score, 1);
    chk("p1_win_active", bus.round_active, 0);

    // 3: second P2 edge inside lockout is ignored
    do_start();
    bus.p2_level = 1'b1; tick(1);
    chk("p2_first", bus.position, 5);
    chk("p2_first_pulse", bus.move_right, 1);
    bus.p2_level = 1'b0; tick(1);
    bus.p2_level = 1'b1; tick(1);
    chk("p2_locked", bus.position, 5);
    chk("p2_locked_pulse", bus.move_right, 0);
    bus.p2_level = 1'b0; tick(2);
    bus.p2_level = 1'b1; tick(1);
    chk("p2_after_lock", bus.position, 6);
    bus.p2_level = 1'b0; tick(5);

    // 4: simultaneous presses cancel, and both players are locked out
    do_start();
    bus.p1_level = 1'b1; bus.p2_level = 1'b1; tick(1);
    chk("tie_position", bus.position, CENTRE);
    chk("tie_left", bus.move_left, 0);
    chk("tie_right", bus.move_right, 0);
    bus.p1_level = 1'b0; bus.p2_level = 1'b0; tick(1);
    bus.p1_level = 1'b1; tick(1);
    chk("tie_p1_locked", bus.position, CENTRE);
    bus.p1_level = 1'b0; bus.p2_level = 1'b1; tick(1);
    chk("tie_p2_locked", bus.position, CENTRE);
    bus.p2_level = 1'b0; tick(5);

    // 5: P2 score saturates at SCORE_MAX
    for (int r = 0; r < 8; r++) begin
      do_start();
      for (int k = 0; k < 4; k++) p2_press(5 + k, 1);
      chk("p2_win_winner", bus.winner, 2);
      chk("p2_win_score", bus.p2_score, (r + 1 < SMAX) ? r + 1 : SMAX);
    end
    chk("p2_sat_score", bus.p2_score, 7);
    p1_press(8, 0);
    p2_press(8, 0);
    chk("done_winner_held", bus.winner, 2);
    do_start();

    // 6: reset mid-round clears everything including scores
    p1_press(3, 1);
    p1_press(2, 1);
    reset = 1'b1;
    tick(1);
    chk("midrst_position", bus.position, CENTRE);
    chk("midrst_p1_score", bus.p1_score, 0);
    chk("midrst_p2_score", bus.p2_score, 0);
    chk("midrst_winner", bus.winner, 0);
    chk("midrst_active", bus.round_active, 0);
    reset = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
